// File: rtl/map_pkg.sv
// World map definitions shared by the map RAM arbiter and its sub-blocks.
// Cell codes, map geometry and requester identifiers.
package map_pkg;

  localparam int MAP_ROWS  = 16;
  localparam int MAP_COLS  = 20;
  localparam int MAP_CELLS = MAP_ROWS * MAP_COLS;
  localparam int ADDR_W    = 9;

  localparam logic [3:0] WALL   = 4'd0;
  localparam logic [3:0] FREE   = 4'd1;
  localparam logic [3:0] TRASH1 = 4'd3;
  localparam logic [3:0] TRASH2 = 4'd4;
  localparam logic [3:0] TRASH3 = 4'd5;
  localparam logic [3:0] BLACK  = 4'd6;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    VID      = 2'd1,
    SEN      = 2'd2,
    WR       = 2'd3
  } req_id_t;

  // Cells are numbered row-major starting at 1; address 0 is the off-map wall.
  function automatic logic [ADDR_W-1:0] cell_addr(input int row, input int col);
    return ADDR_W'(row * MAP_COLS + col + 1);
  endfunction

endpackage

// File: rtl/robot_rr_pick.sv
// Two-way round-robin pick between the sensor read and trash write requesters.
// Combinational pick; the pointer flips only when a contested pick is actually issued.
module robot_rr_pick
  import map_pkg::*;
(
  input  logic clock_50,
  input  logic reset_flag,
  input  logic sen_pend,
  input  logic wr_pend,
  input  logic issue,
  output logic pick_sen,
  output logic pick_wr
);

  req_id_t ptr;

  always_comb begin
    pick_sen = sen_pend & (~wr_pend | (ptr == SEN));
    pick_wr  = wr_pend & (~sen_pend | (ptr == WR));
  end

  always_ff @(posedge clock_50 or posedge reset_flag) begin
    if (reset_flag) begin
      ptr <= SEN;
    end else if (issue && sen_pend && wr_pend) begin
      ptr <= (ptr == SEN) ? WR : SEN;
    end
  end

endmodule

// File: rtl/map_access_arbiter.sv
// Single-port map RAM arbiter: video first, robot requesters round-robin with a starvation guard.
// One registered access per cycle; read data and valid appear the cycle after the grant.
module map_access_arbiter #(
  parameter int ADDR_W    = map_pkg::ADDR_W,
  parameter int DATA_W    = 4,
  parameter int MAP_CELLS = map_pkg::MAP_CELLS,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clock_50,
  input  logic              reset_flag,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  output logic              vid_stall,
  input  logic              sen_req,
  input  logic [ADDR_W-1:0] sen_addr,
  output logic              sen_gnt,
  output logic [DATA_W-1:0] sen_data,
  output logic              sen_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0]  starve_cnt;
  logic              sen_pend, wr_pend, robot_pend;
  logic              vid_win, rob_issue, pick_sen, pick_wr, sen_win, wr_win;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_ok, cmd_ok, rd_ok;
  map_pkg::req_id_t  sel_id, cmd_id, rd_id;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a != '0) && (32'(a) <= 32'(MAP_CELLS));
  endfunction

  // A held request is already being served while its grant pulse is up.
  assign sen_pend   = sen_req & ~sen_gnt;
  assign wr_pend    = wr_req & ~wr_gnt;
  assign robot_pend = sen_pend | wr_pend;
  assign vid_win    = vid_req && (starve_cnt < CNT_W'(MAX_WAIT));
  assign rob_issue  = ~vid_win & robot_pend;
  assign sen_win    = rob_issue & pick_sen;
  assign wr_win     = rob_issue & pick_wr;

  robot_rr_pick u_rr (
    .clock_50   (clock_50),
    .reset_flag (reset_flag),
    .sen_pend   (sen_pend),
    .wr_pend    (wr_pend),
    .issue      (rob_issue),
    .pick_sen   (pick_sen),
    .pick_wr    (pick_wr)
  );

  always_comb begin
    sel_id   = map_pkg::REQ_NONE;
    sel_addr = '0;
    if (vid_win) begin
      sel_id   = map_pkg::VID;
      sel_addr = vid_addr;
    end else if (sen_win) begin
      sel_id   = map_pkg::SEN;
      sel_addr = sen_addr;
    end else if (wr_win) begin
      sel_id   = map_pkg::WR;
      sel_addr = wr_addr;
    end
    sel_ok = addr_ok(sel_addr);
  end

  always_ff @(posedge clock_50 or posedge reset_flag) begin
    if (reset_flag) begin
      sen_gnt    <= 1'b0;
      wr_gnt     <= 1'b0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
      cmd_id     <= map_pkg::REQ_NONE;
      cmd_ok     <= 1'b0;
      rd_id      <= map_pkg::REQ_NONE;
      rd_ok      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      sen_gnt    <= sen_win;
      wr_gnt     <= wr_win;
      ram_addr   <= sel_addr;
      ram_we     <= wr_win & sel_ok;
      ram_wdata  <= (wr_win && sel_ok) ? wr_data : '0;
      cmd_id     <= sel_id;
      cmd_ok     <= sel_ok;
      rd_id      <= (cmd_id == map_pkg::VID || cmd_id == map_pkg::SEN) ? cmd_id : map_pkg::REQ_NONE;
      rd_ok      <= cmd_ok;
      starve_cnt <= (robot_pend && vid_win) ? starve_cnt + 1'b1 : '0;
    end
  end

  // Off-map reads return WALL so border sensing sees a wall.
  always_comb begin
    vid_valid = (rd_id == map_pkg::VID);
    sen_valid = (rd_id == map_pkg::SEN);
    vid_data  = (vid_valid && rd_ok) ? ram_rdata : '0;
    sen_data  = (sen_valid && rd_ok) ? ram_rdata : '0;
    vid_stall = vid_req & (sen_gnt | wr_gnt);
  end

endmodule

// File: tb/tb_map_access_arbiter.sv
// Directed bench for map_access_arbiter with a write-first registered RAM model.
module tb_map_access_arbiter;

  logic       clock_50 = 1'b0;
  logic       reset_flag;
  logic       vid_req, sen_req, wr_req;
  logic [8:0] vid_addr, sen_addr, wr_addr;
  logic [3:0] wr_data;
  logic [3:0] vid_data, sen_data, ram_wdata, ram_rdata;
  logic       vid_valid, vid_stall, sen_gnt, sen_valid, wr_gnt, ram_we;
  logic [8:0] ram_addr;
  logic [3:0] mem [0:511];

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clock_50 = ~clock_50;

  map_access_arbiter dut (
    .clock_50   (clock_50),
    .reset_flag (reset_flag),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .vid_valid  (vid_valid),
    .vid_stall  (vid_stall),
    .sen_req    (sen_req),
    .sen_addr   (sen_addr),
    .sen_gnt    (sen_gnt),
    .sen_data   (sen_data),
    .sen_valid  (sen_valid),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_gnt     (wr_gnt),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Write-first RAM with one-cycle registered read.
  always @(posedge clock_50) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_we ? ram_wdata : mem[ram_addr];
  end

  function automatic logic [3:0] init_val(input int a);
    return 4'((a * 3) % 7);
  endfunction

  task automatic tick();
    @(posedge clock_50);
    #1;
  endtask

  task automatic test_reset();
    reset_flag = 1'b1;
    #1;
    n_checks++;
    if ({sen_gnt, wr_gnt, vid_valid, sen_valid, vid_stall, ram_we} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000", {sen_gnt, wr_gnt, vid_valid, sen_valid, vid_stall, ram_we});
    end
    n_checks++;
    if ({ram_addr, vid_data, sen_data, ram_wdata} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_buses: ram_addr=%0d vid_data=%0d sen_data=%0d ram_wdata=%0d expected all 0",
               ram_addr, vid_data, sen_data, ram_wdata);
    end
    tick();
    tick();
    reset_flag = 1'b0;
    tick();
  endtask

  task automatic test_sensor_read();
    sen_req = 1'b1; sen_addr = 9'd25;
    tick();
    sen_req = 1'b0;
    n_checks++;
    if (sen_gnt !== 1'b1 || ram_addr !== 9'd25 || sen_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sen_grant: gnt=%b addr=%0d valid=%b expected 1 25 0", sen_gnt, ram_addr, sen_valid);
    end
    tick();
    n_checks++;
    if (sen_valid !== 1'b1 || sen_data !== 4'd3 || vid_valid !== 1'b0 || sen_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL sen_data: valid=%b data=%0d vid_valid=%b gnt=%b expected 1 3 0 0",
               sen_valid, sen_data, vid_valid, sen_gnt);
    end
    tick();
    n_checks++;
    if (sen_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sen_valid_pulse: got %b expected 0", sen_valid);
    end
  endtask

  task automatic test_starvation();
    vid_req = 1'b1; vid_addr = 9'd5;
    sen_req = 1'b1; sen_addr = 9'd8;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++;
      if (sen_gnt !== 1'b0 || vid_stall !== 1'b0 || ram_addr !== 9'd5) begin
        n_fail++;
        $display("FAIL starve_vid_win%0d: sen_gnt=%b stall=%b addr=%0d expected 0 0 5", i, sen_gnt, vid_stall, ram_addr);
      end
    end
    tick();
    sen_req = 1'b0;
    n_checks++;
    if (sen_gnt !== 1'b1 || vid_stall !== 1'b1 || ram_addr !== 9'd8 || vid_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_forced: sen_gnt=%b stall=%b addr=%0d vid_valid=%b expected 1 1 8 1",
               sen_gnt, vid_stall, ram_addr, vid_valid);
    end
    tick();
    n_checks++;
    if (sen_gnt !== 1'b0 || vid_stall !== 1'b0 || ram_addr !== 9'd5 || sen_valid !== 1'b1 ||
        sen_data !== 4'd3 || vid_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL starve_resume: gnt=%b stall=%b addr=%0d sen_valid=%b sen_data=%0d vid_valid=%b expected 0 0 5 1 3 0",
               sen_gnt, vid_stall, ram_addr, sen_valid, sen_data, vid_valid);
    end
    n_checks++;
    if (dut.starve_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL starve_cnt_clear: got %0d expected 0", dut.starve_cnt);
    end
    vid_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_alternate();
    sen_req = 1'b1; sen_addr = 9'd41;
    wr_req = 1'b1; wr_addr = 9'd41; wr_data = 4'd1;
    tick();
    n_checks++;
    if (sen_gnt !== 1'b1 || wr_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL alt_1: sen_gnt=%b wr_gnt=%b expected 1 0", sen_gnt, wr_gnt);
    end
    tick();
    n_checks++;
    if (sen_gnt !== 1'b0 || wr_gnt !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== 4'd1 ||
        sen_valid !== 1'b1 || sen_data !== 4'd4) begin
      n_fail++;
      $display("FAIL alt_2: sen_gnt=%b wr_gnt=%b we=%b wdata=%0d sen_valid=%b sen_data=%0d expected 0 1 1 1 1 4",
               sen_gnt, wr_gnt, ram_we, ram_wdata, sen_valid, sen_data);
    end
    tick();
    n_checks++;
    if (sen_gnt !== 1'b1 || wr_gnt !== 1'b0 || ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL alt_3: sen_gnt=%b wr_gnt=%b we=%b expected 1 0 0", sen_gnt, wr_gnt, ram_we);
    end
    tick();
    sen_req = 1'b0; wr_req = 1'b0;
    n_checks++;
    if (sen_gnt !== 1'b0 || wr_gnt !== 1'b1 || sen_valid !== 1'b1 || sen_data !== 4'd1) begin
      n_fail++;
      $display("FAIL alt_4_raw: sen_gnt=%b wr_gnt=%b sen_valid=%b sen_data=%0d expected 0 1 1 1",
               sen_gnt, wr_gnt, sen_valid, sen_data);
    end
    tick();
    tick();
  endtask

  task automatic test_out_of_range();
    logic [8:0] bad_addrs [2];
    bad_addrs[0] = 9'd0;
    bad_addrs[1] = 9'd321;
    for (int i = 0; i < 2; i++) begin
      wr_req = 1'b1; wr_addr = bad_addrs[i]; wr_data = 4'd5;
      tick();
      wr_req = 1'b0;
      n_checks++;
      if (wr_gnt !== 1'b1 || ram_we !== 1'b0 || ram_wdata !== 4'd0) begin
        n_fail++;
        $display("FAIL oob_write_%0d: wr_gnt=%b we=%b wdata=%0d expected 1 0 0", bad_addrs[i], wr_gnt, ram_we, ram_wdata);
      end
      tick();
    end
    sen_req = 1'b1; sen_addr = 9'd0;
    tick();
    sen_req = 1'b0;
    tick();
    n_checks++;
    if (sen_valid !== 1'b1 || sen_data !== 4'd0) begin
      n_fail++;
      $display("FAIL oob_read_0: valid=%b data=%0d expected 1 0", sen_valid, sen_data);
    end
    sen_req = 1'b1; sen_addr = 9'd320;
    tick();
    sen_req = 1'b0;
    tick();
    n_checks++;
    if (sen_valid !== 1'b1 || sen_data !== 4'd1) begin
      n_fail++;
      $display("FAIL edge_read_320: valid=%b data=%0d expected 1 1", sen_valid, sen_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    sen_req = 1'b1; sen_addr = 9'd25;
    tick();
    sen_req = 1'b0;
    n_checks++;
    if (sen_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_gnt: got %b expected 1", sen_gnt);
    end
    reset_flag = 1'b1;
    #1;
    n_checks++;
    if ({sen_gnt, wr_gnt, sen_valid, vid_valid, ram_we} !== 5'b0 || ram_addr !== 9'd0 || sen_data !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_async: flags=%b ram_addr=%0d sen_data=%0d expected 00000 0 0",
               {sen_gnt, wr_gnt, sen_valid, vid_valid, ram_we}, ram_addr, sen_data);
    end
    tick();
    reset_flag = 1'b0;
    n_checks++;
    if (sen_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_valid_a: got %b expected 0", sen_valid);
    end
    sen_req = 1'b1; sen_addr = 9'd25;
    wr_req = 1'b1; wr_addr = 9'd50; wr_data = 4'd6;
    tick();
    sen_req = 1'b0;
    n_checks++;
    if (sen_gnt !== 1'b1 || wr_gnt !== 1'b0 || sen_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ptr_sensor: sen_gnt=%b wr_gnt=%b sen_valid=%b expected 1 0 0", sen_gnt, wr_gnt, sen_valid);
    end
    tick();
    wr_req = 1'b0;
    n_checks++;
    if (wr_gnt !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== 4'd6 || sen_valid !== 1'b1 || sen_data !== 4'd3) begin
      n_fail++;
      $display("FAIL rst_after: wr_gnt=%b we=%b wdata=%0d sen_valid=%b sen_data=%0d expected 1 1 6 1 3",
               wr_gnt, ram_we, ram_wdata, sen_valid, sen_data);
    end
    tick();
    tick();
  endtask

  task automatic test_video_stream();
    int pulses = 0;
    vid_req = 1'b1; vid_addr = 9'd1;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (vid_valid === 1'b1) pulses++;
      if (i >= 2 && i <= 21) begin
        n_checks++;
        if (vid_valid !== 1'b1 || vid_data !== init_val(i - 1) || vid_stall !== 1'b0) begin
          n_fail++;
          $display("FAIL vid_stream_%0d: valid=%b data=%0d stall=%b expected 1 %0d 0",
                   i - 1, vid_valid, vid_data, vid_stall, init_val(i - 1));
        end
      end
      if (i < 20) vid_addr = 9'(i + 1);
      else vid_req = 1'b0;
    end
    n_checks++;
    if (pulses !== 20 || vid_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL vid_pulse_count: got %0d (valid now %b) expected 20 (0)", pulses, vid_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] <= init_val(i);
    mem[0]  <= 4'd7;
    mem[25] <= 4'd3;
    vid_req = 1'b0; sen_req = 1'b0; wr_req = 1'b0;
    vid_addr = '0; sen_addr = '0; wr_addr = '0; wr_data = '0;
    test_reset();
    test_sensor_read();
    test_starvation();
    test_alternate();
    test_out_of_range();
    test_reset_mid_read();
    test_video_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
